monitor_cdecv_clock_gen: RTL and testbench
==========================================

// Module: monitor_cdecv_clock_gen
// PURPOSE
//  Consumer of the monitor's 1-bit software clock output port.
//  Converts the CPU-written clock level into glitch-free, single-cycle clock
//  enables for the CDECV core, and adds a free-run mode with a programmable
//  divider plus a halt stop.
//  Keeps a step counter readable by the monitor.
//  Sits between the monitor PIO outputs and the CDECV core's clock-enable input.
// PARAMETERS
//  DIV_W     16  width of div_ratio (run-mode period = div_ratio+1 clk cycles)
//  PULSE_HI   4  cycles cdecv_clk stays high after each enable pulse (>=1)
//  CNT_W     32  width of step_count
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      reset, asynchronous, active-low
//  step_req     in   1      clock level from monitor PIO; asynchronous to clk, synchronised here
//  run_en       in   1      free-run request; synchronous to clk
//  div_ratio    in   DIV_W  run-mode divider
//  cdecv_halt   in   1      halt from CDECV core; synchronous to clk
//  cnt_clr      in   1      clears step_count; synchronous to clk
//  cdecv_clk_en out  1      one-cycle enable to CDECV core
//  cdecv_clk    out  1      stretched visible clock (LED/probe)
//  running      out  1      state==RUN
//  halted       out  1      state==HALTED
//  step_count   out  CNT_W  number of enables issued, wraps
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, sync flops 0, counters 0.
//  step_req path: 2-flop synchroniser, then a delay flop.
//  - rise = s2 & ~s3, registered into the pulse.
//  - cdecv_clk_en is high for exactly one cycle, during the 3rd clk cycle after
//    the first edge that samples step_req=1.
//  - Falling edges of step_req produce nothing.
//  States: IDLE, RUN, HALTED.
//  - IDLE:   each step_req rise -> one pulse.
//            run_en=1 -> RUN, with the divider loaded with div_ratio.
//  - RUN:    divider decrements every cycle. At 0: pulse, then reload div_ratio
//            (sampled at reload time).
//            div_ratio=0 -> pulse every cycle.
//            First pulse occurs div_ratio+1 cycles after the IDLE->RUN edge.
//            step_req rises are ignored, and not queued.
//            run_en=0 -> IDLE; no pulse in the exit cycle.
//            cdecv_halt=1 -> HALTED; the pulse due in that cycle is suppressed.
//  - HALTED: no pulses, step_req ignored. Exit to IDLE only when run_en=0.
//  - cdecv_halt=1 while in IDLE: manual steps still allowed. The core owns halt
//    semantics; halt gates only run mode.
//  Priority within RUN: cdecv_halt > run_en=0 > divider pulse.
//  cdecv_clk: high in the pulse cycle and the following PULSE_HI-1 cycles.
//  - A new pulse while high reloads the hold counter.
//  - Hence div_ratio+1 <= PULSE_HI gives a constant-high cdecv_clk.
//  step_count:
//  - +1 in every cycle cdecv_clk_en=1; wraps from all-ones to 0.
//  - cnt_clr has priority: with a simultaneous pulse the result is 0, and that
//    pulse is not counted.
//  Reset mid-operation: async return to IDLE, all outputs 0 immediately.
//  - The synchroniser also clears, so a step_req held high over reset release
//    yields one pulse, 3 cycles after release.
// STRUCTURE
//  Shared package monitor_cdecv_pkg:
//  - state encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2);
//  - SYNC_STAGES=2;
//  - default DIV_W/CNT_W.
//  Sub-module monitor_sync_edge:
//  - synchroniser + delay flop;
//  - outputs level and rise pulse;
//  - reused for the other asynchronous monitor inputs.
//  Top level holds: FSM, divider counter, hold counter, step counter.
// TESTING
//  1 Manual step: step_req 0->1 held 10 cycles
//    -> one cdecv_clk_en pulse 3 cycles later, cdecv_clk high 4 cycles,
//       step_count=1; the 1->0 edge gives no pulse.
//  2 Run with div_ratio=3, run_en high 20 cycles
//    -> pulses every 4 cycles (5 pulses), running=1;
//       step_req toggles during RUN add none.
//  3 Halt: in RUN, assert cdecv_halt on a pulse-due cycle
//    -> that pulse is suppressed, halted=1, no further pulses;
//       step_req rise ignored;
//       run_en=0 -> IDLE, after which a step_req rise pulses again.
//  4 div_ratio=0 with PULSE_HI=4 -> cdecv_clk_en every cycle, cdecv_clk constantly 1.
//    Preload step_count=32'hFFFF_FFFF -> wraps to 0.
//  5 cnt_clr coincident with a pulse -> step_count=0.
//    Next pulse -> 1.
//  6 Assert reset_n low mid-RUN with step_req=1
//    -> outputs 0 asynchronously.
//    Release -> exactly one pulse 3 cycles after release, state IDLE.

Source files
------------

// File: rtl/monitor_cdecv_pkg.sv
// Shared definitions for the monitor-side CDECV clock generator:
// FSM state encoding, synchroniser depth and default widths.
package monitor_cdecv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } cdecv_state_e;

   localparam int SYNC_STAGES  = 2;
   localparam int DEF_DIV_W    = 16;
   localparam int DEF_CNT_W    = 32;
   localparam int DEF_PULSE_HI = 4;

endpackage

// File: rtl/monitor_sync_edge.sv
// Synchronises one asynchronous monitor input into clk and flags its rising edge.
// Shared by every asynchronous PIO input of the monitor.
module monitor_sync_edge
   import monitor_cdecv_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   dly_r;

   // Synchroniser chain plus one delay flop for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= '0;
         dly_r  <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
         dly_r  <= sync_r[SYNC_STAGES-1];
      end
   end

   assign level = sync_r[SYNC_STAGES-1];
   assign rise  = sync_r[SYNC_STAGES-1] & ~dly_r;

endmodule

// File: rtl/monitor_cdecv_clock_gen.sv
// Turns the monitor's software clock level into single-cycle CDECV clock
// enables, with a divided free-run mode, halt stop and a readable step counter.
module monitor_cdecv_clock_gen
   import monitor_cdecv_pkg::*;
#(
   parameter int DIV_W    = DEF_DIV_W,
   parameter int PULSE_HI = DEF_PULSE_HI,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             step_req,
   input  logic             run_en,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic             cdecv_halt,
   input  logic             cnt_clr,
   output logic             cdecv_clk_en,
   output logic             cdecv_clk,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] step_count
);

   localparam int                HOLD_W    = (PULSE_HI > 1) ? $clog2(PULSE_HI) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(PULSE_HI - 1);

   cdecv_state_e      state_r;
   cdecv_state_e      state_nxt_s;
   logic [DIV_W-1:0]  div_r;
   logic [DIV_W-1:0]  div_nxt_s;
   logic              en_nxt_s;
   logic [HOLD_W-1:0] hold_r;
   logic              step_level_s;
   logic              step_rise_s;
   logic              step_go_s;

   monitor_sync_edge u_step_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (step_req),
      .level    (step_level_s),
      .rise     (step_rise_s)
   );

   assign step_go_s = step_rise_s & step_level_s;

   // Next state, divider and enable decision; halt beats run exit beats pulse
   always_comb begin
      state_nxt_s = state_r;
      div_nxt_s   = div_r;
      en_nxt_s    = 1'b0;
      case (state_r)
         IDLE: begin
            en_nxt_s = step_go_s;
            if (run_en) begin
               state_nxt_s = RUN;
               div_nxt_s   = div_ratio;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (cdecv_halt) begin
               state_nxt_s = HALTED;
            end else if (!run_en) begin
               state_nxt_s = IDLE;
            end else if (div_r == '0) begin
               en_nxt_s  = 1'b1;
               div_nxt_s = div_ratio;
            end else begin
               div_nxt_s = div_r - DIV_W'(1);
            end
         end
         HALTED: begin
            if (!run_en) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HALTED;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, divider and registered status/enable outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         div_r        <= '0;
         cdecv_clk_en <= 1'b0;
         running      <= 1'b0;
         halted       <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         div_r        <= div_nxt_s;
         cdecv_clk_en <= en_nxt_s;
         running      <= (state_nxt_s == RUN);
         halted       <= (state_nxt_s == HALTED);
      end
   end

   // Stretched visible clock; a fresh pulse restarts the hold window
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_r    <= '0;
         cdecv_clk <= 1'b0;
      end else if (en_nxt_s) begin
         hold_r    <= HOLD_LOAD;
         cdecv_clk <= 1'b1;
      end else if (hold_r != '0) begin
         hold_r    <= hold_r - HOLD_W'(1);
         cdecv_clk <= 1'b1;
      end else begin
         hold_r    <= hold_r;
         cdecv_clk <= 1'b0;
      end
   end

   // Enables issued; a clear wins over a pulse in the same cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_count <= '0;
      end else if (cnt_clr) begin
         step_count <= '0;
      end else if (cdecv_clk_en) begin
         step_count <= step_count + CNT_W'(1);
      end else begin
         step_count <= step_count;
      end
   end

endmodule

// File: tb/tb_monitor_cdecv_clock_gen.sv
// Bench for monitor_cdecv_clock_gen: per-cycle comparison against a behavioural
// model plus directed scenarios with hand-computed expectations.
module tb_monitor_cdecv_clock_gen;

   localparam int PULSE_HI = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        step_req = 1'b0;
   logic        run_en = 1'b0;
   logic [15:0] div_ratio = 16'd0;
   logic        cdecv_halt = 1'b0;
   logic        cnt_clr = 1'b0;

   logic        en, ck, running, halted;
   logic [31:0] step_count;
   logic        n_en, n_ck, n_running, n_halted;
   logic [3:0]  n_count;

   monitor_cdecv_clock_gen #(.DIV_W(16), .PULSE_HI(PULSE_HI), .CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .step_req(step_req), .run_en(run_en),
      .div_ratio(div_ratio), .cdecv_halt(cdecv_halt), .cnt_clr(cnt_clr),
      .cdecv_clk_en(en), .cdecv_clk(ck), .running(running), .halted(halted),
      .step_count(step_count)
   );

   // narrow counter copy so the wrap from all-ones to zero is reachable
   monitor_cdecv_clock_gen #(.DIV_W(16), .PULSE_HI(PULSE_HI), .CNT_W(4)) dut_n (
      .clk(clk), .reset_n(reset_n), .step_req(step_req), .run_en(run_en),
      .div_ratio(div_ratio), .cdecv_halt(cdecv_halt), .cnt_clr(cnt_clr),
      .cdecv_clk_en(n_en), .cdecv_clk(n_ck), .running(n_running), .halted(n_halted),
      .step_count(n_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // model state: mode 0=idle 1=run 2=halted
   int                edge_cnt = 0;
   int                mode = 0;
   bit                prev_samp = 1'b0;
   int                rise_edge = -1000;
   int                run_start = 0;
   int                period = 1;
   int                last_pulse = -1000;
   bit                exp_en = 1'b0;
   bit                exp_clk = 1'b0;
   longint unsigned   exp_cnt = 0;
   bit                m_step_pulse, m_pulse;
   bit                chk_on = 1'b0;

   int                dut_pulses = 0;
   int                last_dut_pulse = -1;
   int                clk_hi_cnt = 0;
   bit                wrap_seen = 1'b0;
   logic [31:0]       wrap_wide = 32'd0;
   logic [3:0]        prev_n = 4'd0;

   always @(posedge clk or negedge reset_n) begin
      edge_cnt++;
      if (!reset_n) begin
         mode = 0; prev_samp = 1'b0; rise_edge = -1000; last_pulse = -1000;
         exp_en = 1'b0; exp_clk = 1'b0; exp_cnt = 0;
      end else begin
         exp_cnt = cnt_clr ? 64'd0 : (exp_en ? exp_cnt + 1 : exp_cnt);
         // a step fires on the 3rd cycle after step_req is first seen high
         m_step_pulse = (edge_cnt == rise_edge + 2);
         if (step_req && !prev_samp) rise_edge = edge_cnt;
         prev_samp = step_req;
         m_pulse = 1'b0;
         case (mode)
            0: begin
               m_pulse = m_step_pulse;
               if (run_en) begin
                  mode = 1; run_start = edge_cnt; period = int'(div_ratio) + 1;
               end
            end
            1: begin
               if (cdecv_halt) mode = 2;
               else if (!run_en) mode = 0;
               else m_pulse = (((edge_cnt - run_start) % period) == 0);
            end
            default: begin
               if (!run_en) mode = 0;
            end
         endcase
         exp_en = m_pulse;
         if (m_pulse) last_pulse = edge_cnt;
         exp_clk = ((edge_cnt - last_pulse) < PULSE_HI);
      end
      #1;
      if (chk_on) begin
         check("m_clk_en", en, exp_en);
         check("m_cdecv_clk", ck, exp_clk);
         check("m_running", running, mode == 1);
         check("m_halted", halted, mode == 2);
         check("m_step_count", step_count, exp_cnt % (64'd1 << 32));
         check("m_step_count_n", n_count, exp_cnt % 64'd16);
      end
      if (en) begin dut_pulses++; last_dut_pulse = edge_cnt; end
      if (ck) clk_hi_cnt++;
      if (prev_n == 4'hF && n_count == 4'h0) begin wrap_seen = 1'b1; wrap_wide = step_count; end
      prev_n = n_count;
   end

   int p0, c0, k0;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_en", en, 0);
      check("rst_clk", ck, 0);
      check("rst_running", running, 0);
      check("rst_halted", halted, 0);
      check("rst_count", step_count, 0);
      reset_n = 1'b1;
      chk_on = 1'b1;
      repeat (3) @(negedge clk);

      // 1: manual step
      p0 = dut_pulses; c0 = clk_hi_cnt; k0 = edge_cnt + 1;
      step_req = 1'b1;
      repeat (10) @(negedge clk);
      step_req = 1'b0;
      repeat (10) @(negedge clk);
      check("t1_pulses", dut_pulses - p0, 1);
      check("t1_latency", last_dut_pulse - k0, 2);
      check("t1_clk_hi", clk_hi_cnt - c0, 4);
      check("t1_count", step_count, 1);

      // 2: free run, div_ratio=3, step_req toggles ignored
      div_ratio = 16'd3; p0 = dut_pulses;
      run_en = 1'b1;
      repeat (5) @(negedge clk);
      check("t2_running", running, 1);
      step_req = 1'b1;
      repeat (5) @(negedge clk);
      step_req = 1'b0;
      repeat (11) @(negedge clk);
      run_en = 1'b0;
      repeat (6) @(negedge clk);
      check("t2_pulses", dut_pulses - p0, 5);
      check("t2_idle", running, 0);
      check("t2_count", step_count, 6);

      // 3: halt on the pulse-due cycle
      p0 = dut_pulses;
      run_en = 1'b1;
      repeat (4) @(negedge clk);
      cdecv_halt = 1'b1;
      @(negedge clk);
      cdecv_halt = 1'b0;
      check("t3_halted", halted, 1);
      check("t3_not_running", running, 0);
      step_req = 1'b1;
      repeat (6) @(negedge clk);
      step_req = 1'b0;
      repeat (4) @(negedge clk);
      check("t3_no_pulse", dut_pulses - p0, 0);
      run_en = 1'b0;
      repeat (2) @(negedge clk);
      check("t3_unhalted", halted, 0);
      p0 = dut_pulses; k0 = edge_cnt + 1;
      step_req = 1'b1;
      repeat (6) @(negedge clk);
      check("t3_step_again", dut_pulses - p0, 1);
      check("t3_latency", last_dut_pulse - k0, 2);
      step_req = 1'b0;
      repeat (4) @(negedge clk);

      // 4: div_ratio=0 -> enable every cycle, clock held high, counter wrap
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("t4_cleared", step_count, 0);
      div_ratio = 16'd0; p0 = dut_pulses;
      run_en = 1'b1;
      repeat (2) @(negedge clk);
      c0 = clk_hi_cnt;
      repeat (18) @(negedge clk);
      check("t4_clk_const", clk_hi_cnt - c0, 18);
      run_en = 1'b0;
      repeat (8) @(negedge clk);
      check("t4_pulses", dut_pulses - p0, 19);
      check("t4_count", step_count, 19);
      check("t4_count_n", n_count, 3);
      check("t4_wrap_seen", wrap_seen, 1);
      check("t4_wrap_wide", wrap_wide, 16);

      // 5: cnt_clr coincident with a pulse
      step_req = 1'b1;
      repeat (3) @(negedge clk);
      check("t5_pulse_now", en, 1);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("t5_cleared", step_count, 0);
      repeat (3) @(negedge clk);
      step_req = 1'b0;
      repeat (4) @(negedge clk);
      step_req = 1'b1;
      repeat (8) @(negedge clk);
      check("t5_next", step_count, 1);

      // 6: reset mid-run with step_req held high
      div_ratio = 16'd3;
      run_en = 1'b1;
      repeat (6) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_en", en, 0);
      check("t6_async_clk", ck, 0);
      check("t6_async_running", running, 0);
      check("t6_async_halted", halted, 0);
      check("t6_async_count", step_count, 0);
      run_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      p0 = dut_pulses; k0 = edge_cnt + 1;
      repeat (8) @(negedge clk);
      check("t6_one_pulse", dut_pulses - p0, 1);
      check("t6_latency", last_dut_pulse - k0, 2);
      check("t6_idle", running, 0);
      check("t6_count", step_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
